// File: rtl/rtc_ascii_snapshot.sv
// RTC/timer field snapshot.
// Captures one field per transfer into a shadow bank of ASCII digit pairs,
// then copies the whole bank to the display bank in a single cycle once the
// frame's field sequence is complete, so the text renderer never sees a torn
// time value.
module rtc_ascii_snapshot #(
    parameter int unsigned NUM_FIELDS       = 11,
    parameter int unsigned NUM_CLOCK_FIELDS = 8,
    parameter int unsigned DATA_W           = 8,
    parameter int unsigned BCD_INPUT        = 1,
    parameter int unsigned MAX_VALUE        = 99
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              timer_mode,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    input  logic [3:0]        rd_idx,
    output logic [6:0]        rd_ascii_u,
    output logic [6:0]        rd_ascii_d,
    output logic              commit,
    output logic              abort,
    output logic              range_err
);

    localparam logic [4:0] TargetAll  = 5'(NUM_FIELDS);
    localparam logic [4:0] TargetClk  = 5'(NUM_CLOCK_FIELDS);
    localparam logic [6:0] AsciiZero  = 7'h30;
    localparam logic [6:0] AsciiQuery = 7'h3F;
    localparam logic [6:0] AsciiSpace = 7'h20;

    typedef enum logic [1:0] {StIdle, StCapture, StCommit} stateT;

    stateT       state;
    logic [3:0]  cnt;
    logic [4:0]  target;
    logic        frameErr;

    logic [6:0]  shadowU [NUM_FIELDS];
    logic [6:0]  shadowD [NUM_FIELDS];
    logic [6:0]  dispU   [NUM_FIELDS];
    logic [6:0]  dispD   [NUM_FIELDS];

    logic [6:0]        convU;
    logic [6:0]        convD;
    logic              convErr;
    logic [DATA_W-1:0] rem;
    logic [3:0]        tens;

    logic       xfer;
    logic       lastXfer;
    logic [4:0] newTarget;

    assign din_ready = (state == StCapture);
    // A frame_start in CAPTURE wins over a simultaneous transfer.
    assign xfer      = din_valid && din_ready && !frame_start;
    assign lastXfer  = ({1'b0, cnt} == (target - 5'd1));
    assign newTarget = timer_mode ? TargetAll : TargetClk;

    // Convert the incoming field to a tens/units ASCII pair, '?' when illegal.
    always_comb begin
        convU   = AsciiZero;
        convD   = AsciiZero;
        convErr = 1'b0;
        rem     = din;
        tens    = 4'd0;
        if (BCD_INPUT != 0) begin
            convErr = (din[7:4] > 4'd9) || (din[3:0] > 4'd9);
            convU   = AsciiZero + {3'b000, din[3:0]};
            convD   = AsciiZero + {3'b000, din[7:4]};
        end else begin
            convErr = (32'(din) > MAX_VALUE);
            // Nine conditional subtractions cover every legal value below 100.
            for (int k = 0; k < 9; k++) begin
                if (rem >= DATA_W'(10)) begin
                    rem  = rem - DATA_W'(10);
                    tens = tens + 4'd1;
                end
            end
            convU = AsciiZero + {3'b000, rem[3:0]};
            convD = AsciiZero + {3'b000, tens};
        end
        if (convErr) begin
            convU = AsciiQuery;
            convD = AsciiQuery;
        end
    end

    // Capture sequencing, strobes and error tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            target    <= TargetClk;
            frameErr  <= 1'b0;
            commit    <= 1'b0;
            abort     <= 1'b0;
            range_err <= 1'b0;
        end else begin
            commit <= 1'b0;
            abort  <= 1'b0;
            case (state)
                StIdle: begin
                    if (frame_start) begin
                        target   <= newTarget;
                        cnt      <= 4'd0;
                        frameErr <= 1'b0;
                        state    <= StCapture;
                    end
                end
                StCapture: begin
                    if (frame_start) begin
                        // Incomplete sequence: drop it and restart the frame.
                        abort    <= 1'b1;
                        target   <= newTarget;
                        cnt      <= 4'd0;
                        frameErr <= 1'b0;
                    end else if (xfer) begin
                        cnt <= cnt + 4'd1;
                        if (convErr) begin
                            frameErr  <= 1'b1;
                            range_err <= 1'b1;
                        end
                        if (lastXfer) begin
                            state  <= StCommit;
                            commit <= 1'b1;
                        end
                    end
                end
                StCommit: begin
                    range_err <= frameErr;
                    if (frame_start) begin
                        target   <= newTarget;
                        cnt      <= 4'd0;
                        frameErr <= 1'b0;
                        state    <= StCapture;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Shadow bank write on each accepted field.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadowU[i] <= AsciiZero;
                shadowD[i] <= AsciiZero;
            end
        end else if (xfer) begin
            shadowU[cnt] <= convU;
            shadowD[cnt] <= convD;
        end
    end

    // Atomic shadow-to-display copy of the slots captured this frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                dispU[i] <= AsciiZero;
                dispD[i] <= AsciiZero;
            end
        end else if (state == StCommit) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (5'(i) < target) begin
                    dispU[i] <= shadowU[i];
                    dispD[i] <= shadowD[i];
                end
            end
        end
    end

    // Registered display read; out-of-range slots read as spaces.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ascii_u <= 7'h00;
            rd_ascii_d <= 7'h00;
        end else if (32'(rd_idx) < NUM_FIELDS) begin
            rd_ascii_u <= dispU[rd_idx];
            rd_ascii_d <= dispD[rd_idx];
        end else begin
            rd_ascii_u <= AsciiSpace;
            rd_ascii_d <= AsciiSpace;
        end
    end

endmodule
